// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter
//   Shares one port of a dual-port RAM between two requesters with round-robin
//   arbitration. After reset it clears the whole RAM through the same port
//   before it accepts any request. Read responses are routed back to the
//   requester that issued them by a tag pipeline matched to the RAM read
//   latency.
//
// Optional build macro:
//   DPRAM_ARB_HAZARD_STALL_EN - keep a short history of issued writes and
//   refuse to grant a read whose address matches a write that may not have
//   landed in the RAM yet.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid/ready          request handshake (ready is combinational)
//   reqN_we/addr/wdata        request type, address, write data
//   rspN_valid/rdata          read response (rdata is ram_dout passed through)
//   init_done                 RAM clear sweep finished
//   ram_en/we/addr/din        registered RAM port controls
//   ram_dout                  RAM port read data
module dpram_port_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 3,
  parameter int READ_LATENCY  = 1,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic                     req0_we,
  input  logic [ADDRESS_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0]    req0_wdata,
  output logic                     rsp0_valid,
  output logic [DATA_WIDTH-1:0]    rsp0_rdata,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic                     req1_we,
  input  logic [ADDRESS_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0]    req1_wdata,
  output logic                     rsp1_valid,
  output logic [DATA_WIDTH-1:0]    rsp1_rdata,
  output logic                     init_done,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_din,
  input  logic [DATA_WIDTH-1:0]    ram_dout
);

  localparam int DCW = (WRITE_LATENCY > 1) ? $clog2(WRITE_LATENCY) : 1;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_DRAIN = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t                   state_q;
  logic [ADDRESS_WIDTH-1:0] init_cnt_q;
  logic [DCW-1:0]           drain_cnt_q;
  logic                     last1_q;     // 1: req1 granted last, so req0 wins a tie
  logic                     init_done_q;
  logic                     ram_en_q;
  logic                     ram_we_q;
  logic [ADDRESS_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0]    ram_din_q;
  logic                     tag_v_q  [READ_LATENCY+1];
  logic                     tag_id_q [READ_LATENCY+1];

  logic                     haz0, haz1;
  logic                     elig0, elig1;
  logic                     gnt0, gnt1, gnt_any, gnt_we;
  logic [ADDRESS_WIDTH-1:0] gnt_addr;
  logic [DATA_WIDTH-1:0]    gnt_wdata;

`ifdef DPRAM_ARB_HAZARD_STALL_EN
  logic                     hist_v_q [WRITE_LATENCY];
  logic [ADDRESS_WIDTH-1:0] hist_a_q [WRITE_LATENCY];

  // A read may not be granted while a write to its address is still in flight.
  always_comb begin
    haz0 = 1'b0;
    haz1 = 1'b0;
    for (int i = 0; i < WRITE_LATENCY; i++) begin
      if (hist_v_q[i] && !req0_we && (hist_a_q[i] == req0_addr)) haz0 = 1'b1;
      if (hist_v_q[i] && !req1_we && (hist_a_q[i] == req1_addr)) haz1 = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WRITE_LATENCY; i++) hist_v_q[i] <= 1'b0;
    end else begin
      hist_v_q[0] <= gnt_any & gnt_we;
      hist_a_q[0] <= gnt_addr;
      for (int i = 1; i < WRITE_LATENCY; i++) begin
        hist_v_q[i] <= hist_v_q[i-1];
        hist_a_q[i] <= hist_a_q[i-1];
      end
    end
  end
`else
  assign haz0 = 1'b0;
  assign haz1 = 1'b0;
`endif

  assign elig0     = (state_q == S_RUN) && req0_valid && !haz0;
  assign elig1     = (state_q == S_RUN) && req1_valid && !haz1;
  assign gnt0      = elig0 && (!elig1 || last1_q);
  assign gnt1      = elig1 && (!elig0 || !last1_q);
  assign gnt_any   = gnt0 | gnt1;
  assign gnt_we    = gnt1 ? req1_we    : req0_we;
  assign gnt_addr  = gnt1 ? req1_addr  : req0_addr;
  assign gnt_wdata = gnt1 ? req1_wdata : req0_wdata;

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign init_done  = init_done_q;
  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_din    = ram_din_q;

  // The tag reaching the last stage lines up with ram_dout of the matching read.
  assign rsp0_valid = tag_v_q[READ_LATENCY] && !tag_id_q[READ_LATENCY];
  assign rsp1_valid = tag_v_q[READ_LATENCY] &&  tag_id_q[READ_LATENCY];
  assign rsp0_rdata = ram_dout;
  assign rsp1_rdata = ram_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      init_cnt_q  <= '0;
      drain_cnt_q <= '0;
      last1_q     <= 1'b1;
      init_done_q <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      for (int i = 0; i <= READ_LATENCY; i++) begin
        tag_v_q[i]  <= 1'b0;
        tag_id_q[i] <= 1'b0;
      end
    end else begin
      tag_v_q[0]  <= gnt_any & !gnt_we;
      tag_id_q[0] <= gnt1;
      for (int i = 1; i <= READ_LATENCY; i++) begin
        tag_v_q[i]  <= tag_v_q[i-1];
        tag_id_q[i] <= tag_id_q[i-1];
      end

      case (state_q)
        S_INIT: begin
          ram_en_q   <= 1'b1;
          ram_we_q   <= 1'b1;
          ram_addr_q <= init_cnt_q;
          ram_din_q  <= '0;
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == '1) begin
            state_q     <= S_DRAIN;
            drain_cnt_q <= '0;
          end
        end
        S_DRAIN: begin
          // The last clear write is on the port during the first DRAIN cycle.
          ram_en_q <= 1'b0;
          ram_we_q <= 1'b0;
          if (drain_cnt_q == DCW'(WRITE_LATENCY - 1)) begin
            state_q     <= S_RUN;
            init_done_q <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + DCW'(1);
          end
        end
        S_RUN: begin
          ram_en_q <= gnt_any;
          ram_we_q <= gnt_any & gnt_we;
          if (gnt_any) begin
            ram_addr_q <= gnt_addr;
            ram_din_q  <= gnt_wdata;
          end
          if (gnt0) last1_q <= 1'b0;
          if (gnt1) last1_q <= 1'b1;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
module tb_dpram_port_arbiter;

  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;
  localparam int RL    = 3;
`ifdef DPRAM_ARB_HAZARD_STALL_EN
  localparam int WL    = 3;
`else
  localparam int WL    = 1;
`endif
  localparam int WI    = (WL > 1) ? WL - 2 : 0;

  logic          clk;
  logic          rst;
  logic          req0_valid, req0_ready, req0_we;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          rsp0_valid;
  logic [DW-1:0] rsp0_rdata;
  logic          req1_valid, req1_ready, req1_we;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          rsp1_valid;
  logic [DW-1:0] rsp1_rdata;
  logic          init_done, ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  dpram_port_arbiter #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .init_done(init_done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM port model: read-first, reads valid RL cycles after the access cycle,
  // a write lands at the end of its WL-th cycle.
  logic [DW-1:0] mem [DEPTH] = '{default: 8'hEE};
  logic [DW-1:0] rd_pipe [RL];
  logic          wq_v [WL];
  logic [AW-1:0] wq_a [WL];
  logic [DW-1:0] wq_d [WL];

  always @(posedge clk) begin
    rd_pipe[0] <= mem[ram_addr];
    for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
    wq_v[0] <= ram_en & ram_we;
    wq_a[0] <= ram_addr;
    wq_d[0] <= ram_din;
    for (int k = 1; k < WL; k++) begin
      wq_v[k] <= wq_v[k-1];
      wq_a[k] <= wq_a[k-1];
      wq_d[k] <= wq_d[k-1];
    end
    if (WL == 1) begin
      if (ram_en && ram_we) mem[ram_addr] <= ram_din;
    end else if (wq_v[WI]) begin
      mem[wq_a[WI]] <= wq_d[WI];
    end
  end
  assign ram_dout = rd_pipe[RL-1];

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic rst_applied = 1'b1;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_applied <= rst;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference model: expected memory contents as seen by accepted requests,
  // round-robin owner, recently accepted writes and expected responses.
  typedef struct { logic [DW-1:0] data; int due; } exp_t;
  typedef struct { int c; logic [AW-1:0] a; } wr_t;
  exp_t          q0[$];
  exp_t          q1[$];
  wr_t           wr_hist[$];
  logic [DW-1:0] ref_mem [DEPTH];
  int            k = 0;
  int            last_gnt = 1;
  logic          prev_v = 1'b0, prev_we = 1'b0;
  logic [AW-1:0] prev_a = '0;
  logic [DW-1:0] prev_d = '0;

  function automatic logic blocked(input logic we, input logic [AW-1:0] a);
`ifdef DPRAM_ARB_HAZARD_STALL_EN
    if (we) return 1'b0;
    foreach (wr_hist[i])
      if ((cyc - wr_hist[i].c) >= 1 && (cyc - wr_hist[i].c) <= WL && wr_hist[i].a == a) return 1'b1;
    return 1'b0;
`else
    return 1'b0 & we & (a == a);
`endif
  endfunction

  // Issue tracker: checks grants and RAM port, pushes expected responses.
  always @(negedge clk) begin
    logic exp_done, e0, e1, g0, g1;
    if (rst_applied) begin
      chk("reset_outputs", 32'({init_done, req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                                ram_en, ram_we, ram_addr, ram_din}), 32'h0);
      k = 1;
      last_gnt = 1;
      prev_v = 1'b0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      wr_hist.delete();
    end else begin
      exp_done = (k >= DEPTH + WL);
      chk("init_done", 32'(init_done), 32'(exp_done));
      if (k <= DEPTH) begin
        chk("init_sweep", 32'({ram_en, ram_we, ram_addr, ram_din}),
            32'({1'b1, 1'b1, AW'(k - 1), 8'h00}));
      end else begin
        chk("ram_en", 32'(ram_en), 32'(prev_v));
        chk("ram_we", 32'(ram_we), 32'(prev_v & prev_we));
        if (prev_v) chk("ram_addr", 32'(ram_addr), 32'(prev_a));
        if (prev_v && prev_we) chk("ram_din", 32'(ram_din), 32'(prev_d));
      end
      while (wr_hist.size() > 0 && (cyc - wr_hist[0].c) > WL) void'(wr_hist.pop_front());
      e0 = exp_done && req0_valid && !blocked(req0_we, req0_addr);
      e1 = exp_done && req1_valid && !blocked(req1_we, req1_addr);
      g0 = e0 && (!e1 || last_gnt == 1);
      g1 = e1 && (!e0 || last_gnt == 0);
      chk("req0_ready", 32'(req0_ready), 32'(g0));
      chk("req1_ready", 32'(req1_ready), 32'(g1));
      prev_v = g0 | g1;
      if (g0) begin
        prev_we = req0_we; prev_a = req0_addr; prev_d = req0_wdata; last_gnt = 0;
        if (req0_we) begin ref_mem[req0_addr] = req0_wdata; wr_hist.push_back('{cyc, req0_addr}); end
        else q0.push_back('{ref_mem[req0_addr], cyc + 1 + RL});
      end else if (g1) begin
        prev_we = req1_we; prev_a = req1_addr; prev_d = req1_wdata; last_gnt = 1;
        if (req1_we) begin ref_mem[req1_addr] = req1_wdata; wr_hist.push_back('{cyc, req1_addr}); end
        else q1.push_back('{ref_mem[req1_addr], cyc + 1 + RL});
      end
      k++;
    end
  end

  // Response monitor: pops the scoreboard whenever a response appears or is due.
  always @(negedge clk) begin
    exp_t e;
    if (rst_applied) begin
      chk("rsp_during_reset", 32'({rsp0_valid, rsp1_valid}), 32'h0);
      q0.delete();
      q1.delete();
    end else begin
      chk("rsp_exclusive", 32'(rsp0_valid & rsp1_valid), 32'h0);
      if (rsp0_valid) begin
        if (q0.size() == 0) begin
          tests++; fails++;
          $display("FAIL rsp0_unexpected: got rsp0_valid=1 expected no response at cycle %0d", cyc);
        end else begin
          e = q0.pop_front();
          chk("rsp0_cycle", 32'(cyc), 32'(e.due));
          chk("rsp0_rdata", 32'(rsp0_rdata), 32'(e.data));
        end
      end else if (q0.size() > 0 && q0[0].due <= cyc) begin
        e = q0.pop_front();
        chk("rsp0_valid_due", 32'(rsp0_valid), 32'h1);
      end
      if (rsp1_valid) begin
        if (q1.size() == 0) begin
          tests++; fails++;
          $display("FAIL rsp1_unexpected: got rsp1_valid=1 expected no response at cycle %0d", cyc);
        end else begin
          e = q1.pop_front();
          chk("rsp1_cycle", 32'(cyc), 32'(e.due));
          chk("rsp1_rdata", 32'(rsp1_rdata), 32'(e.data));
        end
      end else if (q1.size() > 0 && q1[0].due <= cyc) begin
        e = q1.pop_front();
        chk("rsp1_valid_due", 32'(rsp1_valid), 32'h1);
      end
    end
  end

  task automatic issue(input int n, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int   t;
    logic got;
    if (n == 0) begin req0_valid = 1'b1; req0_we = we; req0_addr = a; req0_wdata = d; end
    else        begin req1_valid = 1'b1; req1_we = we; req1_addr = a; req1_wdata = d; end
    t = 0;
    got = 1'b0;
    while (!got && t < 60) begin
      @(negedge clk);
      got = (n == 0) ? req0_ready : req1_ready;
      t++;
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL handshake_timeout: requester %0d got no ready within %0d cycles", n, t);
    end
    @(posedge clk); #1;
    if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    idle(3);
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    idle(DEPTH + WL + 2);

    // cleared RAM reads back zero; write-then-read across requesters
    issue(0, 1'b0, 3'd5, 8'h00);
    issue(0, 1'b1, 3'd3, 8'hA5);
    issue(1, 1'b0, 3'd3, 8'h00);
    idle(RL + 2);
`ifdef DPRAM_ARB_HAZARD_STALL_EN
    issue(0, 1'b1, 3'd2, 8'h3C);
    issue(1, 1'b0, 3'd2, 8'h00);
    idle(RL + 2);
`endif

    // req0 alone, one request every cycle
    req0_valid = 1'b1;
    req0_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req0_addr = AW'($urandom);
      idle(1);
    end
    req0_valid = 1'b0;
    idle(RL + 2);

    // both valid, all reads: strict alternation
    req0_valid = 1'b1; req1_valid = 1'b1; req0_we = 1'b0; req1_we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      req0_addr = AW'($urandom);
      req1_addr = AW'($urandom);
      idle(1);
    end

    // reset while reads are in flight, then a fresh clear sweep
    idle(1);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    idle(DEPTH + WL + 2);

    // randomized mixed traffic
    for (int i = 0; i < 300; i++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_we    = 1'($urandom_range(0, 1));
      req1_we    = 1'($urandom_range(0, 1));
      req0_addr  = AW'($urandom);
      req1_addr  = AW'($urandom);
      req0_wdata = DW'($urandom);
      req1_wdata = DW'($urandom);
      idle(1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    idle(RL + 6);
    @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'h0);
    chk("q1_drained", 32'(q1.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
